// File: rtl/div_module.sv
// div_module: multi-cycle radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU
module div_module #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            DIV_vld,
  input  logic [XLEN-1:0] DIV_OPRA,
  input  logic [XLEN-1:0] DIV_OPRB,
  input  logic [2:0]      funct3,
  input  logic [4:0]      rd_index,
  input  logic            div_kill,
  input  logic            div_ack,
  output logic            div_busy,
  output logic            div_res_vld,
  output logic [XLEN-1:0] div_result,
  output logic [4:0]      div_rd_index
);
  localparam int CW = $clog2(XLEN) + 1;
  localparam logic [XLEN-1:0] MIN = {1'b1, {(XLEN-1){1'b0}}};
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0] quo_q, quo_d, rem_q, rem_d, dvs_q, dvs_d, res_q, res_d;
  logic [4:0] rd_q, rd_d, rdl_q, rdl_d;
  logic rem_sel_q, rem_sel_d, sign_q_q, sign_q_d, sign_r_q, sign_r_d, vld_q, vld_d;
  logic [XLEN-1:0] abs_a, abs_b, shf;
  logic [XLEN:0] trial;
  always_comb begin
    abs_a = (~funct3[0] & DIV_OPRA[XLEN-1]) ? -DIV_OPRA : DIV_OPRA;
    abs_b = (~funct3[0] & DIV_OPRB[XLEN-1]) ? -DIV_OPRB : DIV_OPRB;
    shf = {rem_q[XLEN-2:0], quo_q[XLEN-1]};
    trial = {1'b0, shf} - {1'b0, dvs_q};
    state_d = state_q;
    cnt_d = cnt_q;
    quo_d = quo_q;
    rem_d = rem_q;
    dvs_d = dvs_q;
    res_d = res_q;
    rd_d = rd_q;
    rdl_d = rdl_q;
    rem_sel_d = rem_sel_q;
    sign_q_d = sign_q_q;
    sign_r_d = sign_r_q;
    vld_d = (state_q == DONE) & ~(div_ack & vld_q);
    if (div_kill) begin
      state_d = IDLE;
      vld_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: if (DIV_vld & funct3[2]) begin
          rem_sel_d = funct3[1];
          sign_q_d = ~funct3[0] & (DIV_OPRA[XLEN-1] ^ DIV_OPRB[XLEN-1]);
          sign_r_d = ~funct3[0] & DIV_OPRA[XLEN-1];
          rdl_d = rd_index;
          quo_d = abs_a;
          dvs_d = abs_b;
          rem_d = '0;
          cnt_d = '0;
          state_d = CALC;
          // Divide-by-zero and signed overflow bypass the iteration entirely
          if (DIV_OPRB == '0) begin
            state_d = DONE;
            res_d = funct3[1] ? DIV_OPRA : '1;
            rd_d = rd_index;
          end else if (~funct3[0] & (DIV_OPRA == MIN) & (DIV_OPRB == '1)) begin
            state_d = DONE;
            res_d = funct3[1] ? '0 : MIN;
            rd_d = rd_index;
          end
        end
        CALC: begin
          quo_d = {quo_q[XLEN-2:0], ~trial[XLEN]};
          rem_d = trial[XLEN] ? shf : trial[XLEN-1:0];
          cnt_d = cnt_q + 1'b1;
          state_d = (cnt_q == CW'(XLEN-1)) ? FIX : CALC;
        end
        FIX: begin
          res_d = rem_sel_q ? (sign_r_q ? -rem_q : rem_q) : (sign_q_q ? -quo_q : quo_q);
          rd_d = rdl_q;
          state_d = DONE;
        end
        default: state_d = (div_ack & vld_q) ? IDLE : DONE;
      endcase
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      quo_q <= '0;
      rem_q <= '0;
      dvs_q <= '0;
      res_q <= '0;
      rd_q <= '0;
      rdl_q <= '0;
      rem_sel_q <= 1'b0;
      sign_q_q <= 1'b0;
      sign_r_q <= 1'b0;
      vld_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      quo_q <= quo_d;
      rem_q <= rem_d;
      dvs_q <= dvs_d;
      res_q <= res_d;
      rd_q <= rd_d;
      rdl_q <= rdl_d;
      rem_sel_q <= rem_sel_d;
      sign_q_q <= sign_q_d;
      sign_r_q <= sign_r_d;
      vld_q <= vld_d;
    end
  end
  assign div_busy = state_q != IDLE;
  assign div_res_vld = vld_q;
  assign div_result = res_q;
  assign div_rd_index = rd_q;
endmodule

// File: tb/tb_div_module.sv
// tb_div_module: directed and model-checked tests for div_module
module tb_div_module;
  logic clk = 0, rst = 1, DIV_vld = 0, div_kill = 0, div_ack = 0;
  logic [31:0] DIV_OPRA = 0, DIV_OPRB = 0;
  logic [2:0] funct3 = 0;
  logic [4:0] rd_index = 0;
  logic div_busy, div_res_vld;
  logic [31:0] div_result;
  logic [4:0] div_rd_index;
  int n_cmp = 0, n_err = 0;
  localparam logic [2:0] DIV = 3'b100, DIVU = 3'b101, REM = 3'b110, REMU = 3'b111;
  always #5 clk = ~clk;
  div_module dut (
    .clk(clk), .rst(rst), .DIV_vld(DIV_vld), .DIV_OPRA(DIV_OPRA), .DIV_OPRB(DIV_OPRB),
    .funct3(funct3), .rd_index(rd_index), .div_kill(div_kill), .div_ack(div_ack),
    .div_busy(div_busy), .div_res_vld(div_res_vld), .div_result(div_result),
    .div_rd_index(div_rd_index)
  );
  function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa, sb;
    sa = a;
    sb = b;
    if (b == 0) return f3[1] ? a : 32'hFFFFFFFF;
    if (!f3[0]) begin
      if (a == 32'h80000000 && b == 32'hFFFFFFFF) return f3[1] ? 32'h0 : 32'h80000000;
      return f3[1] ? sa % sb : sa / sb;
    end
    return f3[1] ? a % b : a / b;
  endfunction
  task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    @(negedge clk);
    DIV_vld = 1; funct3 = f3; DIV_OPRA = a; DIV_OPRB = b; rd_index = rd;
    @(posedge clk); #1;
    DIV_vld = 0;
  endtask
  task automatic do_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd,
                       output logic [31:0] res, output logic [4:0] rdo, output int cyc);
    issue(f3, a, b, rd);
    cyc = 0;
    while (!div_res_vld && cyc < 100) begin @(posedge clk); #1; cyc++; end
    res = div_result; rdo = div_rd_index;
    div_ack = 1;
    @(posedge clk); #1;
    div_ack = 0;
  endtask
  task automatic test_reset;
    n_cmp++;
    if ({div_busy, div_res_vld, div_result, div_rd_index} !== '0) begin
      n_err++; $display("FAIL reset: busy=%b vld=%b res=%h rd=%0d, required all 0", div_busy, div_res_vld, div_result, div_rd_index);
    end
  endtask
  task automatic test_unsigned;
    logic [31:0] r; logic [4:0] d; int c;
    do_op(DIVU, 100, 7, 5, r, d, c);
    n_cmp++;
    if (r !== 14 || d !== 5 || c !== 34) begin
      n_err++; $display("FAIL divu_100_7: res=%0d rd=%0d lat=%0d, required 14 5 34", r, d, c);
    end
    do_op(REMU, 100, 7, 6, r, d, c);
    n_cmp++;
    if (r !== 2 || d !== 6 || c !== 34) begin
      n_err++; $display("FAIL remu_100_7: res=%0d rd=%0d lat=%0d, required 2 6 34", r, d, c);
    end
  endtask
  task automatic test_signed;
    logic [31:0] r; logic [4:0] d; int c;
    do_op(DIV, -7, 2, 1, r, d, c);
    n_cmp++;
    if (r !== 32'hFFFFFFFD || c !== 34) begin n_err++; $display("FAIL div_m7_2: res=%h lat=%0d, required fffffffd 34", r, c); end
    do_op(REM, -7, 2, 2, r, d, c);
    n_cmp++;
    if (r !== 32'hFFFFFFFF) begin n_err++; $display("FAIL rem_m7_2: res=%h, required ffffffff", r); end
    do_op(REM, 7, -2, 3, r, d, c);
    n_cmp++;
    if (r !== 1) begin n_err++; $display("FAIL rem_7_m2: res=%h, required 00000001", r); end
  endtask
  task automatic test_special;
    logic [31:0] r; logic [4:0] d; int c;
    do_op(DIVU, 5, 0, 7, r, d, c);
    n_cmp++;
    if (r !== 32'hFFFFFFFF || d !== 7 || c !== 1) begin n_err++; $display("FAIL divu_by0: res=%h rd=%0d lat=%0d, required ffffffff 7 1", r, d, c); end
    do_op(REMU, 5, 0, 8, r, d, c);
    n_cmp++;
    if (r !== 5 || d !== 8 || c !== 1) begin n_err++; $display("FAIL remu_by0: res=%h rd=%0d lat=%0d, required 5 8 1", r, d, c); end
    do_op(DIV, 32'h80000000, 32'hFFFFFFFF, 9, r, d, c);
    n_cmp++;
    if (r !== 32'h80000000 || c !== 1) begin n_err++; $display("FAIL div_ovf: res=%h lat=%0d, required 80000000 1", r, c); end
    do_op(REM, 32'h80000000, 32'hFFFFFFFF, 10, r, d, c);
    n_cmp++;
    if (r !== 0 || c !== 1) begin n_err++; $display("FAIL rem_ovf: res=%h lat=%0d, required 0 1", r, c); end
  endtask
  task automatic test_kill;
    logic [31:0] r; logic [4:0] d; int c; bit seen;
    issue(DIVU, 1000, 3, 9);
    repeat (10) @(posedge clk);
    #1 div_kill = 1;
    @(posedge clk); #1;
    div_kill = 0;
    n_cmp++;
    if (div_busy !== 0 || div_res_vld !== 0) begin n_err++; $display("FAIL kill_calc: busy=%b vld=%b, required 0 0", div_busy, div_res_vld); end
    seen = 0;
    repeat (40) begin @(posedge clk); #1; seen |= div_res_vld; end
    n_cmp++;
    if (seen) begin n_err++; $display("FAIL kill_no_result: vld seen=1, required 0"); end
    @(negedge clk);
    DIV_vld = 1; div_kill = 1; funct3 = DIVU; DIV_OPRA = 4; DIV_OPRB = 0;
    @(posedge clk); #1;
    DIV_vld = 0; div_kill = 0;
    n_cmp++;
    if (div_busy !== 0) begin n_err++; $display("FAIL kill_idle_drop: busy=%b, required 0", div_busy); end
    do_op(DIVU, 9, 3, 3, r, d, c);
    n_cmp++;
    if (r !== 3 || d !== 3 || c !== 34) begin n_err++; $display("FAIL after_kill: res=%0d rd=%0d lat=%0d, required 3 3 34", r, d, c); end
  endtask
  task automatic test_reset_mid;
    logic [31:0] r; logic [4:0] d; int c;
    issue(DIVU, 1000, 3, 12);
    repeat (10) @(posedge clk);
    #1 rst = 1;
    #1;
    n_cmp++;
    if ({div_busy, div_res_vld, div_result, div_rd_index} !== '0) begin
      n_err++; $display("FAIL reset_mid: busy=%b vld=%b res=%h rd=%0d, required all 0", div_busy, div_res_vld, div_result, div_rd_index);
    end
    @(negedge clk) rst = 0;
    do_op(DIVU, 50, 5, 13, r, d, c);
    n_cmp++;
    if (r !== 10 || d !== 13 || c !== 34) begin n_err++; $display("FAIL after_reset: res=%0d rd=%0d lat=%0d, required 10 13 34", r, d, c); end
  endtask
  task automatic test_hold;
    int c;
    issue(DIV, 100, -7, 17);
    funct3 = DIVU; DIV_OPRA = 55; DIV_OPRB = 0; rd_index = 1;
    c = 0;
    while (!div_res_vld && c < 100) begin DIV_vld = (c % 3 == 0); @(posedge clk); #1; c++; end
    DIV_vld = 0;
    n_cmp++;
    if (div_result !== 32'hFFFFFFF2 || div_rd_index !== 17 || c !== 34) begin
      n_err++; $display("FAIL hold_first: res=%h rd=%0d lat=%0d, required fffffff2 17 34", div_result, div_rd_index, c);
    end
    for (int i = 0; i < 5; i++) begin
      DIV_vld = i[0];
      @(posedge clk); #1;
      n_cmp++;
      if (div_res_vld !== 1 || div_busy !== 1 || div_result !== 32'hFFFFFFF2 || div_rd_index !== 17) begin
        n_err++; $display("FAIL hold_%0d: vld=%b busy=%b res=%h rd=%0d, required 1 1 fffffff2 17", i, div_res_vld, div_busy, div_result, div_rd_index);
      end
    end
    DIV_vld = 0; div_ack = 1;
    @(posedge clk); #1;
    div_ack = 0;
    n_cmp++;
    if (div_busy !== 0 || div_res_vld !== 0 || div_result !== 32'hFFFFFFF2 || div_rd_index !== 17) begin
      n_err++; $display("FAIL hold_ack: busy=%b vld=%b res=%h rd=%0d, required 0 0 fffffff2 17", div_busy, div_res_vld, div_result, div_rd_index);
    end
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (div_busy !== 0) begin n_err++; $display("FAIL hold_idle: busy=%b, required 0", div_busy); end
  endtask
  task automatic test_random;
    logic [31:0] a, b, r, e; logic [4:0] d; logic [2:0] f; int c;
    for (int i = 0; i < 24; i++) begin
      f = 3'b100 | 3'($urandom_range(0, 3));
      case ($urandom_range(0, 4))
        0: a = 0; 1: a = 32'hFFFFFFFF; 2: a = 32'h80000000; default: a = $urandom;
      endcase
      case ($urandom_range(0, 5))
        0: b = 0; 1: b = 32'hFFFFFFFF; 2: b = 32'h80000000; 3: b = $urandom_range(1, 20); default: b = $urandom;
      endcase
      e = model(f, a, b);
      do_op(f, a, b, 5'(i), r, d, c);
      n_cmp++;
      if (r !== e || d !== 5'(i)) begin
        n_err++; $display("FAIL rand_%0d f3=%b a=%h b=%h: res=%h rd=%0d, required %h %0d", i, f, a, b, r, d, e, i);
      end
    end
  endtask
  task automatic test_back_to_back;
    int c;
    logic [31:0] av[4] = '{32'd1000, 32'hFFFFFF9C, 32'd77, 32'h7FFFFFFF};
    logic [31:0] bv[4] = '{32'd10, 32'd9, 32'hFFFFFFFB, 32'd2};
    logic [2:0] fv[4] = '{DIVU, DIV, REM, REMU};
    for (int i = 0; i < 4; i++) begin
      issue(fv[i], av[i], bv[i], 5'(20 + i));
      c = 0;
      while (!div_res_vld && c < 100) begin @(posedge clk); #1; c++; end
      n_cmp++;
      if (div_result !== model(fv[i], av[i], bv[i]) || div_rd_index !== 5'(20 + i)) begin
        n_err++; $display("FAIL b2b_res_%0d: res=%h rd=%0d, required %h %0d", i, div_result, div_rd_index, model(fv[i], av[i], bv[i]), 20 + i);
      end
      div_ack = 1;
      @(posedge clk); #1;
      c++;
      div_ack = 0;
      n_cmp++;
      if (div_busy !== 0 || c !== 35) begin n_err++; $display("FAIL b2b_occ_%0d: busy=%b cycles=%0d, required 0 35", i, div_busy, c); end
    end
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    test_reset;
    @(negedge clk) rst = 0;
    test_unsigned;
    test_signed;
    test_special;
    test_kill;
    test_reset_mid;
    test_hold;
    test_random;
    test_back_to_back;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
